// File: rtl/reset_seq.sv
// reset_seq: reset synchroniser and ordered release sequencer.
//
// Takes a raw asynchronous active-low reset and produces N_OUT synchronous
// active-high resets. All outputs assert asynchronously on arst_n, stay held
// for STRETCH cycles after the synchronised reset deasserts, then release in
// ascending index order, GAP cycles apart. done rises with the last release.
//
// Optional feature: define RESET_SEQ_SOFT_RST_EN to enable the synchronous
// software reset input. Without it soft_rst is ignored and RUN is left only
// through arst_n.
//
// Parameters:
//   SYNC_STAGES  synchroniser flop count (>= 2)
//   N_OUT        number of output resets (1..16)
//   STRETCH      cycles all outputs stay asserted after sync release (>= 1)
//   GAP          cycles between consecutive output releases (>= 1)
//
// Ports:
//   clk       in   domain clock
//   arst_n    in   asynchronous active-low reset
//   soft_rst  in   synchronous software reset request, active-high
//   rst       out  [N_OUT-1:0] active-high resets, rst[0] released first
//   done      out  high once every rst bit has been released
module reset_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned N_OUT       = 4,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned GAP         = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             soft_rst,
  output logic [N_OUT-1:0] rst,
  output logic             done
);

  // Counter is sized for the larger of the two programmable intervals.
  localparam int unsigned CntMax = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int unsigned CNT_W  = $clog2(CntMax + 1);
  localparam int unsigned IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CNT_W-1:0] StretchLast = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IdxLast     = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser: ones shift in after arst_n deasserts.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Soft reset request
  // ---------------------------------------------------------------------------
`ifdef RESET_SEQ_SOFT_RST_EN
  logic soft_req;
  assign soft_req = soft_rst;
`else
  logic unused_soft_rst;
  assign unused_soft_rst = soft_rst;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] rst_q, rst_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;

    unique case (state_q)
      StHold: begin
        if (!sync_n) begin
          cnt_d = '0;
        end else if (cnt_q == StretchLast) begin
          // rst_q is a run of ones above a run of zeros, so masking with its
          // own left shift clears exactly the lowest still-asserted bit.
          rst_d = rst_q & (rst_q << 1);
          cnt_d = '0;
          idx_d = IDX_W'(1);
          if (N_OUT == 1) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StRelease: begin
        if (cnt_q == GapLast) begin
          rst_d = rst_q & (rst_q << 1);
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IdxLast) begin
            state_d = StRun;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StRun: begin
        rst_d  = '0;
        done_d = 1'b1;
      end

      default: begin
        state_d = StHold;
      end
    endcase

`ifdef RESET_SEQ_SOFT_RST_EN
    // Overrides any terminal-count event on the same edge.
    if (soft_req) begin
      state_d = StHold;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
    end
`endif
  end

  assign rst  = rst_q;
  assign done = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: default configuration (2/4/16/8) plus a corner
// instance (SYNC_STAGES=3, N_OUT=1, STRETCH=1, GAP=1) sharing clk and arst_n.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       arst_n = 1'b1;
  logic       soft_rst = 1'b0;
  logic [3:0] rst;
  logic       done;
  logic [0:0] rst_c;
  logic       done_c;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  reset_seq #(
    .SYNC_STAGES(2),
    .N_OUT      (4),
    .STRETCH    (16),
    .GAP        (8)
  ) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .soft_rst(soft_rst),
    .rst     (rst),
    .done    (done)
  );

  reset_seq #(
    .SYNC_STAGES(3),
    .N_OUT      (1),
    .STRETCH    (1),
    .GAP        (1)
  ) dut_c (
    .clk     (clk),
    .arst_n  (arst_n),
    .soft_rst(soft_rst),
    .rst     (rst_c),
    .done    (done_c)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    int         edge_n;
    logic [3:0] exp_rst;
    logic       exp_done;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [3:0] act_rst, input logic [3:0] exp_rst,
                       input logic act_done, input logic exp_done);
    checks++;
    if (act_rst !== exp_rst || act_done !== exp_done) begin
      errors++;
      $display("FAIL %s at edge %0d: rst=%h done=%b, expected rst=%h done=%b",
               name, edge_cnt, act_rst, act_done, exp_rst, exp_done);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Walks the release schedule; edges are counted from arst_n release, so a
  // soft reset at edge S is aligned by starting the count at SYNC_STAGES.
  task automatic run_table(input string name, input int start_edge);
    edge_cnt = start_edge;
    for (int i = 0; i < 11; i++) begin
      while (edge_cnt < tbl[i].edge_n) tick();
      check(name, rst, tbl[i].exp_rst, done, tbl[i].exp_done);
    end
  endtask

  // Called just after an edge: pulse arst_n between edges, release mid-cycle.
  task automatic restart();
    #2 arst_n = 1'b0;
    #2 arst_n = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1,  4'hF, 1'b0};
    tbl[1]  = '{2,  4'hF, 1'b0};
    tbl[2]  = '{17, 4'hF, 1'b0};
    tbl[3]  = '{18, 4'hE, 1'b0};
    tbl[4]  = '{25, 4'hE, 1'b0};
    tbl[5]  = '{26, 4'hC, 1'b0};
    tbl[6]  = '{33, 4'hC, 1'b0};
    tbl[7]  = '{34, 4'h8, 1'b0};
    tbl[8]  = '{41, 4'h8, 1'b0};
    tbl[9]  = '{42, 4'h0, 1'b1};
    tbl[10] = '{46, 4'h0, 1'b1};

    // Power-up with the clock stopped.
    #2 arst_n = 1'b0;
    #3;
    check("powerup", rst, 4'hF, done, 1'b0);
    check("powerup_corner", {3'b0, rst_c}, 4'h1, done_c, 1'b0);

    clk_en = 1'b1;
    repeat (3) tick();
    check("held_in_reset", rst, 4'hF, done, 1'b0);

    #4 arst_n = 1'b1;
    edge_cnt = 0;
    repeat (3) tick();
    check("corner_edge3", {3'b0, rst_c}, 4'h1, done_c, 1'b0);
    tick();
    check("corner_edge4", {3'b0, rst_c}, 4'h0, done_c, 1'b1);
    run_table("release", 4);

    // Mid-RELEASE asynchronous abort.
    restart();
    while (edge_cnt < 26) tick();
    check("pre_arst_abort", rst, 4'hC, done, 1'b0);
    #3 arst_n = 1'b0;
    #1;
    check("arst_abort_async", rst, 4'hF, done, 1'b0);
    arst_n = 1'b1;
    run_table("arst_restart", 0);

`ifdef RESET_SEQ_SOFT_RST_EN
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("soft_pulse_at_s", rst, 4'hF, done, 1'b0);
    run_table("soft_pulse", 2);

    soft_rst = 1'b1;
    repeat (5) tick();
    soft_rst = 1'b0;
    check("soft_held_at_s", rst, 4'hF, done, 1'b0);
    run_table("soft_held", 2);

    restart();
    while (edge_cnt < 26) tick();
    check("pre_soft_abort", rst, 4'hC, done, 1'b0);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("soft_abort", rst, 4'hF, done, 1'b0);
    run_table("soft_abort_seq", 2);
`else
    // soft_rst held high through a whole sequence must not disturb it.
    restart();
    soft_rst = 1'b1;
    run_table("soft_ignored_seq", 0);
    soft_rst = 1'b0;
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    tick();
    check("soft_ignored_run", rst, 4'h0, done, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
# reset_seq

Parametrised reset synchroniser and sequencer. It takes a raw asynchronous active-low reset and produces N_OUT synchronous active-high resets. Each reset asserts asynchronously, is held for a programmable stretch, then is released in index order with a fixed gap between releases. It sits at the top of every clock domain and replaces the single-output synchroniser, adding stretch, ordered release, a done flag and an optional software reset.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser flop count (≥2).
- N_OUT, 4, number of output resets (1..16).
- STRETCH, 16, cycles all outputs stay asserted after the synchronised reset deasserts (≥1).
- GAP, 8, cycles between consecutive output releases (≥1).
- CNT_W, $clog2(max(STRETCH,GAP)+1), internal counter width. It is derived, not overridden.

Ports:
- clk  in  1  domain clock. One clock; no other clock enters the block.
- arst_n  in  1  asynchronous, active-low reset.
- soft_rst  in  1  synchronous software reset request, active-high.
- rst  out  N_OUT  active-high resets; rst[0] is released first.
- done  out  1  high once every rst bit has been released.

## Operation
- Synchroniser: a chain of SYNC_STAGES flops with D tied to 1, all cleared asynchronously by arst_n. The last stage is sync_n.
- arst_n low, asynchronously and without a clock edge:
  - rst = all ones, done = 0.
  - State HOLD, cnt = 0, sync chain = 0.
- These are the reset values of every output and register.
- State machine, evaluated on every clk edge:
  - HOLD:
    - sync_n = 0: cnt held at 0.
    - sync_n = 1 and cnt < STRETCH-1: cnt++.
    - sync_n = 1 and cnt == STRETCH-1: clear rst[0], idx = 1, cnt = 0.
    - Then go to RELEASE, or go to RUN with done = 1 if N_OUT = 1.
  - RELEASE:
    - cnt < GAP-1: cnt++.
    - cnt == GAP-1: clear rst[idx], idx++, cnt = 0.
    - If idx was N_OUT-1: go to RUN and set done = 1 on the same edge.
  - RUN: outputs static; rst = 0 and done = 1.
- soft_rst (only with the macro) is sampled high at an edge in any state. On that edge:
  - rst = all ones, done = 0, cnt = 0, idx = 0, state HOLD.
  - soft_rst held high keeps the block in HOLD with cnt = 0.
  - soft_rst has priority over counter terminal events on the same edge.
- The sync chain is untouched by soft_rst.
- The rst bits clear only in ascending index order and never reassert except by arst_n or soft_rst.

## Timing
- arst_n falling: rst and done respond asynchronously, within flop clear-to-Q delay.
- arst_n rising, with edge 1 the first clk edge after deassertion:
  - sync_n rises at edge SYNC_STAGES.
  - rst[0] falls at edge SYNC_STAGES+STRETCH.
  - rst[i] falls at edge SYNC_STAGES+STRETCH+i·GAP.
  - done rises on the edge where rst[N_OUT-1] falls.
- Soft reset, with S the last edge at which soft_rst is sampled high:
  - rst[0] falls at S+STRETCH.
  - rst[i] falls at S+STRETCH+i·GAP.
- arst_n reasserted mid-sequence: immediate asynchronous return to the reset values. The full sequence restarts on deassertion.
- All outputs come directly from flops, with no combinational path to outputs. The sole exception is the asynchronous arst_n clear/set.

## Configuration
- Macro RESET_SEQ_SOFT_RST_EN.
- Defined: soft_rst behaves as described above.
- Undefined:
  - soft_rst is left unconnected internally and has no effect.
  - Once in RUN, the block leaves only on arst_n.
  - The soft-reset priority logic is not synthesised.

## Test plan
All scenarios use SYNC_STAGES=2, N_OUT=4, STRETCH=16, GAP=8 unless stated otherwise.
- Power-up: arst_n=0 with clk stopped -> rst=4'hF, done=0 with no clock edge.
- Release: deassert arst_n -> rst[0] falls at edge 18, rst[1] at 26, rst[2] at 34, rst[3] at 42, done rises at 42. No earlier changes.
- Soft reset in RUN (macro defined): 1-cycle soft_rst pulse sampled at edge S -> rst=4'hF, done=0 at S; rst[0] falls at S+16; done at S+40. Repeat with soft_rst held 5 cycles -> timing counts from the last high edge.
- Abort mid-RELEASE: soft_rst once rst=4'b1100 -> rst=4'hF next edge; full 16/8 sequence repeats. Same with an asynchronous arst_n pulse -> immediate 4'hF, sequence restarts from the synchroniser.
- Corner: N_OUT=1, STRETCH=1, GAP=1, SYNC_STAGES=3 -> rst[0] and done change at edge 4 after arst_n rises.
- Macro undefined: soft_rst pulses in RUN and RELEASE -> no change to rst, done or the release schedule.
